gray_decode_arbiter: RTL and testbench
======================================

// Module: gray_decode_arbiter
// PURPOSE
//  Shares one combinational Gray-to-binary decode stage among NREQ requesters.
//  - Each requester presents a Gray-coded word with a valid/ready handshake.
//  - A round-robin arbiter grants one requester per cycle.
//  - The decoded binary word is returned through a one-entry registered output,
//    tagged with the requester index.
//  - Sits between the position/pointer sources and the consumers of binary values.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  DATA_W  8   Gray/binary word width (>=2)
//  IDW     2   width of out_id; must satisfy 2**IDW >= NREQ
//  CNT_W   16  width of the accepted-transfer counter
// PORTS
//  clk        in   1             single clock; all logic on rising edge
//  rst_n      in   1             asynchronous, active-low reset
//  req_valid  in   NREQ          requester i has a word pending
//  req_data   in   NREQ*DATA_W   Gray word of requester i at [i*DATA_W +: DATA_W]
//  req_ready  out  NREQ          one-hot (or zero); word of requester i accepted this cycle
//  out_valid  out  1             decoded result held
//  out_data   out  DATA_W        binary result
//  out_id     out  IDW           index of the requester that produced out_data
//  out_ready  in   1             consumer takes result when out_valid & out_ready
//  acc_count  out  CNT_W         number of accepted requests, wraps modulo 2**CNT_W
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - out_valid=0, out_data=0, out_id=0, acc_count=0.
//   - RR pointer=0, so requester 0 has highest priority.
//   - FSM = EMPTY.
//  Decode:
//   - bin[DATA_W-1] = g[DATA_W-1].
//   - bin[k] = bin[k+1] ^ g[k] for k = DATA_W-2 down to 0.
//   - Purely combinational on the granted word.
//  Arbitration (combinational):
//   - Search starts at ptr and wraps: ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
//   - The first index with req_valid=1 is granted.
//   - ptr moves to (granted+1) mod NREQ only when a transfer is accepted.
//   - With no acceptance, ptr holds; a withdrawn request is simply skipped.
//  Handshake:
//   - space = ~out_valid | out_ready.
//   - req_ready[i] = grant[i] & space.
//   - At most one bit of req_ready is high.
//   - req_ready never depends on out_data.
//   - Accept = |(req_valid & req_ready).
//  FSM (2 states):
//   - EMPTY: out_valid=0. Accept -> load out_data/out_id, go to FULL.
//   - FULL: out_valid=1; out_data/out_id are stable while out_ready=0.
//       * out_ready=1 and accept in the same cycle: reload, stay FULL
//         (back-to-back, 1 result/cycle).
//       * out_ready=1 and no accept: go to EMPTY. out_data/out_id keep
//         their last value (don't-care).
//  Latency and throughput:
//   - Accept in cycle N gives out_valid=1 in cycle N+1.
//   - Sustained throughput is 1 word/cycle when out_ready=1.
//  acc_count:
//   - Increments by 1 on each accept.
//   - Wraps from 2**CNT_W-1 to 0.
//  Fairness:
//   - With all NREQ requesters always valid and out_ready=1, grants cycle 0,1,..,NREQ-1,0,...
//   - No requester waits more than NREQ accepts.
//  Reset mid-operation:
//   - A pending result is dropped and nothing is replayed.
//   - The next grant after release goes to the lowest-index valid requester.
// TESTING
//  1 Reset: rst_n=0 mid-transfer -> out_valid=0, acc_count=0, req_ready=0 immediately,
//    without waiting for a clock edge.
//  2 Decode: a single requester sends Gray 8'hC0, 8'h80, 8'hFF, 8'h01 with out_ready=1
//    -> out_data 8'h80, 8'hFF, 8'hAA, 8'h01 on consecutive cycles, with out_id=0.
//  3 Round-robin: all 4 valid, out_ready=1 for 8 cycles -> out_id 0,1,2,3,0,1,2,3;
//    acc_count=8.
//  4 Backpressure: out_ready=0 while FULL -> req_ready=4'b0000; out_data/out_id stable
//    for 5 cycles. Release -> next result appears 1 cycle later with no loss.
//  5 Skip/withdraw: ptr=1, only req_valid=4'b1001 -> grant 3, then 0.
//    Drop req 3 before grant -> grant 0.
//  6 Wrap: CNT_W=4, 17 accepts -> acc_count=1. Full random bench against a reference
//    Gray decode model checks no lost or duplicated words.

Source files
------------

// File: rtl/gray_decode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_decode_arbiter
//  Description : Round-robin arbiter sharing one combinational Gray-to-binary
//                decoder among NREQ requesters. The result is returned through
//                a one-entry registered output tagged with the requester index.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_decode_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  parameter int IDW    = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDW-1:0]           out_id,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         acc_count
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [IDW-1:0] c_LAST_IDX = IDW'(NREQ - 1);

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_q;
  logic [IDW-1:0]      id_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                w_found;
  logic [IDW-1:0]      w_gidx;
  logic [NREQ-1:0]     w_grant;
  logic [DATA_W-1:0]   w_gray;
  logic [DATA_W-1:0]   w_bin;
  logic                w_space;
  logic                w_accept;
  int                  w_idx;

  // Round-robin search starting at ptr_q, wrapping; first valid index wins
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_grant = '0;
    w_gray  = req_data[DATA_W-1:0];
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(ptr_q) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && (i == w_idx) && req_valid[i]) begin
          w_found    = 1'b1;
          w_gidx     = IDW'(i);
          w_grant[i] = 1'b1;
          w_gray     = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Each binary bit is the XOR of all Gray bits at and above it
  for (genvar k = 0; k < DATA_W; k++) begin : g_dec
    assign w_bin[k] = ^w_gray[DATA_W-1:k];
  end

  // Output slot can take a word when empty or being drained this cycle.
  // rst_n gates ready so nothing is offered while reset is asserted.
  assign w_space   = (state_q == EMPTY) | out_ready;
  assign req_ready = w_grant & {NREQ{w_space & rst_n}};
  assign w_accept  = |(req_valid & req_ready);

  // Next-state logic for the output slot FSM and the round-robin pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      EMPTY: if (w_accept) state_d = FULL;
      FULL: begin
        if (w_accept)      state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (w_accept) begin
      ptr_d = (w_gidx == c_LAST_IDX) ? '0 : w_gidx + IDW'(1);
    end
  end

  // State and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Result slot and accepted-transfer counter, loaded on every accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      id_q   <= '0;
      cnt_q  <= '0;
    end else if (w_accept) begin
      data_q <= w_bin;
      id_q   <= w_gidx;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign acc_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_decode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_decode_arbiter
//  Description : Self-checking bench for gray_decode_arbiter (NREQ=4,
//                DATA_W=8, IDW=2, CNT_W=4): directed vector table, reset and
//                counter-wrap sequences, and a randomized reference model run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_decode_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ready;
  logic [3:0]  acc_count;

  int n_chk;
  int n_err;

  gray_decode_arbiter #(
    .NREQ  (4),
    .DATA_W(8),
    .IDW   (2),
    .CNT_W (4)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id),
    .out_ready(out_ready),
    .acc_count(acc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  e_rr;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_id;
    logic [3:0]  e_cnt;
  } vec_t;

  // Words 3..0 are Gray codes of 3,2,1,0, so decoded value equals index
  localparam logic [31:0] c_D = 32'h02030100;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gdec(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  task automatic add(input logic [3:0] rv, input logic [31:0] d, input logic ordy,
                     input logic [3:0] rr, input logic ov, input logic [7:0] od,
                     input logic [1:0] id, input logic [3:0] cnt);
    vec_t v;
    v.rv = rv; v.data = d; v.ordy = ordy;
    v.e_rr = rr; v.e_ov = ov; v.e_od = od; v.e_id = id; v.e_cnt = cnt;
    tbl.push_back(v);
  endtask

  // Randomized model state
  int         m_ptr;
  bit         m_full;
  logic [7:0] m_data;
  logic [1:0] m_id;
  logic [3:0] m_cnt;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req_valid = '0;
    req_data  = c_D;
    out_ready = 1'b0;

    // Round robin from reset: grants 0,1,2,3,0,1,2,3 then drain
    add(4'b1111, c_D, 1, 4'b0001, 0, 8'h00, 2'd0, 4'd0);
    add(4'b1111, c_D, 1, 4'b0010, 1, 8'h00, 2'd0, 4'd1);
    add(4'b1111, c_D, 1, 4'b0100, 1, 8'h01, 2'd1, 4'd2);
    add(4'b1111, c_D, 1, 4'b1000, 1, 8'h02, 2'd2, 4'd3);
    add(4'b1111, c_D, 1, 4'b0001, 1, 8'h03, 2'd3, 4'd4);
    add(4'b1111, c_D, 1, 4'b0010, 1, 8'h00, 2'd0, 4'd5);
    add(4'b1111, c_D, 1, 4'b0100, 1, 8'h01, 2'd1, 4'd6);
    add(4'b1111, c_D, 1, 4'b1000, 1, 8'h02, 2'd2, 4'd7);
    add(4'b0000, c_D, 1, 4'b0000, 1, 8'h03, 2'd3, 4'd8);
    // Decode stream from requester 0: C0,80,FF,01 -> 80,FF,AA,01
    add(4'b0001, 32'h020301C0, 1, 4'b0001, 0, 8'h03, 2'd3, 4'd8);
    add(4'b0001, 32'h02030180, 1, 4'b0001, 1, 8'h80, 2'd0, 4'd9);
    add(4'b0001, 32'h020301FF, 1, 4'b0001, 1, 8'hFF, 2'd0, 4'd10);
    add(4'b0001, 32'h02030101, 1, 4'b0001, 1, 8'hAA, 2'd0, 4'd11);
    add(4'b0000, c_D,          1, 4'b0000, 1, 8'h01, 2'd0, 4'd12);
    // Backpressure: load req 2, hold 5 cycles, release -> req 3 next
    add(4'b0100, c_D, 0, 4'b0100, 0, 8'h01, 2'd0, 4'd12);
    for (int i = 0; i < 5; i++) add(4'b1111, c_D, 0, 4'b0000, 1, 8'h02, 2'd2, 4'd13);
    add(4'b1111, c_D, 1, 4'b1000, 1, 8'h02, 2'd2, 4'd13);
    add(4'b0000, c_D, 1, 4'b0000, 1, 8'h03, 2'd3, 4'd14);
    // Skip/withdraw with ptr=1; counter wraps 15 -> 0 on the way
    add(4'b0001, c_D, 1, 4'b0001, 0, 8'h03, 2'd3, 4'd14);
    add(4'b1001, c_D, 1, 4'b1000, 1, 8'h00, 2'd0, 4'd15);
    add(4'b1001, c_D, 1, 4'b0001, 1, 8'h03, 2'd3, 4'd0);
    add(4'b1001, c_D, 0, 4'b0000, 1, 8'h00, 2'd0, 4'd1);
    add(4'b0001, c_D, 1, 4'b0001, 1, 8'h00, 2'd0, 4'd1);
    add(4'b0000, c_D, 1, 4'b0000, 1, 8'h00, 2'd0, 4'd2);
    add(4'b0000, c_D, 0, 4'b0000, 0, 8'h00, 2'd0, 4'd2);

    // Reset values while held in reset
    repeat (2) @(negedge clk);
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_id", out_id, 2'd0);
    check("rst_acc_count", acc_count, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      req_valid = tbl[i].rv;
      req_data  = tbl[i].data;
      out_ready = tbl[i].ordy;
      #2;
      check($sformatf("v%0d_req_ready", i), req_ready, tbl[i].e_rr);
      check($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("v%0d_out_data", i), out_data, tbl[i].e_od);
      check($sformatf("v%0d_out_id", i), out_id, tbl[i].e_id);
      check($sformatf("v%0d_acc_count", i), acc_count, tbl[i].e_cnt);
    end

    // Asynchronous reset mid-transfer: slot full, requests pending
    @(negedge clk);
    req_valid = 4'b1111;
    req_data  = c_D;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_acc_count", acc_count, 4'd0);
    check("async_rst_req_ready", req_ready, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1110;
    out_ready = 1'b1;
    #2;
    check("post_rst_grant", req_ready, 4'b0010);
    check("post_rst_out_valid", out_valid, 1'b0);

    // 17 accepts total from reset -> counter wraps to 1
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req_valid = 4'b0001;
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #2;
    check("wrap_acc_count", acc_count, 4'd1);
    check("wrap_out_valid", out_valid, 1'b1);
    check("wrap_out_id", out_id, 2'd0);

    // Randomized run against a reference model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_full = 1'b0;
    m_data = '0;
    m_id   = '0;
    m_cnt  = '0;
    for (int c = 0; c < 300; c++) begin
      int        g;
      bit        found;
      bit        space;
      logic [3:0] e_rr;
      if (c != 0) @(negedge clk);
      req_valid = 4'($urandom);
      req_data  = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      #2;
      found = 1'b0;
      g = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && req_valid[(m_ptr + k) % 4]) begin
          found = 1'b1;
          g = (m_ptr + k) % 4;
        end
      end
      space = !m_full || out_ready;
      e_rr = (found && space) ? 4'(1 << g) : 4'b0000;
      check("rnd_req_ready", req_ready, e_rr);
      check("rnd_out_valid", out_valid, m_full);
      if (m_full) begin
        check("rnd_out_data", out_data, m_data);
        check("rnd_out_id", out_id, m_id);
      end
      check("rnd_acc_count", acc_count, m_cnt);
      if (found && space) begin
        m_full = 1'b1;
        m_data = gdec(req_data[g*8 +: 8]);
        m_id   = 2'(g);
        m_ptr  = (g + 1) % 4;
        m_cnt  = m_cnt + 4'd1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
